// File: rtl/bit_deser_pkg.sv
// Shared types and helpers for the serial-to-parallel deserialiser.
// Parity support is compiled in only when BIT_DESER_PARITY_EN is defined.
package bit_deser_pkg;

  typedef enum logic [1:0] {
    StShift = 2'd0,
    StPar   = 2'd1,
    StHold  = 2'd2
  } state_e;

  // Widest word the parity helper can reduce.
  localparam int unsigned MaxWidth = 64;

  // Reduction XOR over a zero-extended word; zero padding leaves the result unchanged.
  function automatic logic parity_of(input logic [MaxWidth-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/bit_deser_ctrl.sv
// Handshake FSM and bit counter for bit_deser.
// Adds a parity-bit state when BIT_DESER_PARITY_EN is defined.
module bit_deser_ctrl
  import bit_deser_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic out_ready,
  output logic in_ready,
  output logic out_valid,
`ifdef BIT_DESER_PARITY_EN
  output logic par_en,
`endif
  output logic shift_en
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StShift;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    shift_en  = 1'b0;
`ifdef BIT_DESER_PARITY_EN
    par_en    = 1'b0;
`endif
    unique case (state_q)
      StShift: begin
        in_ready = 1'b1;
        if (in_valid) begin
          shift_en = 1'b1;
          if (cnt_q == LastCnt) begin
            cnt_d = '0;
`ifdef BIT_DESER_PARITY_EN
            state_d = StPar;
`else
            state_d = StHold;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
`ifdef BIT_DESER_PARITY_EN
      StPar: begin
        in_ready = 1'b1;
        if (in_valid) begin
          par_en  = 1'b1;
          state_d = StHold;
        end
      end
`endif
      StHold: begin
        // No bit is taken in HOLD, even on the transfer cycle.
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = StShift;
        end
      end
      default: begin
        state_d = StShift;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/bit_deser.sv
// Serial-to-parallel deserialiser: WIDTH bits in, one word out with valid/ready.
// Optional even-parity check per word enabled by defining BIT_DESER_PARITY_EN.
module bit_deser
  import bit_deser_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
`ifdef BIT_DESER_PARITY_EN
  output logic             parity_err,
`endif
  input  logic             out_ready
);

  logic             shift_en;
  logic [WIDTH-1:0] sh_q, sh_d;

`ifdef BIT_DESER_PARITY_EN
  logic par_en;
`endif

  bit_deser_ctrl #(
    .WIDTH(WIDTH)
  ) u_ctrl (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .out_ready(out_ready),
    .in_ready (in_ready),
    .out_valid(out_valid),
`ifdef BIT_DESER_PARITY_EN
    .par_en   (par_en),
`endif
    .shift_en (shift_en)
  );

  always_comb begin
    sh_d = sh_q;
    if (shift_en) begin
      if (MSB_FIRST != 0) begin
        sh_d = {sh_q[WIDTH-2:0], in_bit};
      end else begin
        sh_d = {in_bit, sh_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q <= '0;
    end else begin
      sh_q <= sh_d;
    end
  end

  // The shift register is frozen outside SHIFT, so it doubles as the output word.
  assign out_data = sh_q;

`ifdef BIT_DESER_PARITY_EN
  logic                perr_q, perr_d;
  logic [MaxWidth-1:0] sh_ext;

  always_comb begin
    sh_ext              = '0;
    sh_ext[WIDTH-1:0]   = sh_q;
    perr_d              = perr_q;
    if (par_en) begin
      perr_d = parity_of(sh_ext) ^ in_bit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= perr_d;
    end
  end

  assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_bit_deser.sv
// Directed bench for bit_deser: MSB-first and LSB-first instances share one stimulus.
// Parity checks are included when BIT_DESER_PARITY_EN is defined.
module tb_bit_deser;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_bit;
  logic       out_ready;
  logic       rdy_m, vld_m, rdy_l, vld_l;
  logic [7:0] data_m, data_l;
`ifdef BIT_DESER_PARITY_EN
  logic       perr_m, perr_l;
  localparam bit Par = 1'b1;
`else
  localparam bit Par = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bit_deser #(
    .WIDTH(8),
    .MSB_FIRST(1)
  ) u_msb (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .in_ready  (rdy_m),
    .out_valid (vld_m),
    .out_data  (data_m),
`ifdef BIT_DESER_PARITY_EN
    .parity_err(perr_m),
`endif
    .out_ready (out_ready)
  );

  bit_deser #(
    .WIDTH(8),
    .MSB_FIRST(0)
  ) u_lsb (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .in_ready  (rdy_l),
    .out_valid (vld_l),
    .out_data  (data_l),
`ifdef BIT_DESER_PARITY_EN
    .parity_err(perr_l),
`endif
    .out_ready (out_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Streams w MSB-first, optionally with idle cycles between bits, then the parity bit.
  task automatic send_word(input logic [7:0] w, input logic p, input bit gaps);
    for (int i = 7; i >= 0; i--) begin
      in_valid = 1'b1;
      in_bit   = w[i];
      tick();
      if (i > 0 || Par) check("early_valid", {31'd0, vld_m}, 32'd0);
      if (gaps && i > 0) begin
        in_valid = 1'b0;
        in_bit   = ~in_bit;
        tick();
      end
    end
    if (Par) begin
      in_valid = 1'b1;
      in_bit   = p;
      tick();
    end
    in_valid = 1'b0;
    in_bit   = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_rdy", {31'd0, rdy_m}, 32'd1);
    check("rst_vld", {31'd0, vld_m}, 32'd0);
    check("rst_data", {24'd0, data_m}, 32'h00);
    check("rst_data_l", {24'd0, data_l}, 32'h00);

    // Back-to-back B2, parity bit 1 (odd total -> error).
    out_ready = 1'b1;
    send_word(8'hB2, 1'b1, 1'b0);
    check("b2_vld", {31'd0, vld_m}, 32'd1);
    check("b2_rdy", {31'd0, rdy_m}, 32'd0);
    check("b2_data", {24'd0, data_m}, 32'hB2);
    check("b2_data_l", {24'd0, data_l}, 32'h4D);
    check("b2_vld_l", {31'd0, vld_l}, 32'd1);
`ifdef BIT_DESER_PARITY_EN
    check("b2_perr1", {31'd0, perr_m}, 32'd1);
    check("b2_perr1_l", {31'd0, perr_l}, 32'd1);
`endif
    tick();
    check("b2_vld_1cyc", {31'd0, vld_m}, 32'd0);
    check("b2_rdy_back", {31'd0, rdy_m}, 32'd1);

    // Same word with parity bit 0 (even total -> ok).
    send_word(8'hB2, 1'b0, 1'b0);
    check("b2b_data", {24'd0, data_m}, 32'hB2);
`ifdef BIT_DESER_PARITY_EN
    check("b2_perr0", {31'd0, perr_m}, 32'd0);
`endif
    tick();

    // Back-pressure: 3 cycles in HOLD, in_bit offered but ignored.
    out_ready = 1'b0;
    send_word(8'h3C, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_bit   = 1'b1;
    for (int c = 0; c < 3; c++) begin
      check("hold_vld", {31'd0, vld_m}, 32'd1);
      check("hold_rdy", {31'd0, rdy_m}, 32'd0);
      check("hold_data", {24'd0, data_m}, 32'h3C);
      if (c < 2) tick();
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("hold_xfer_vld", {31'd0, vld_m}, 32'd0);
    check("hold_xfer_rdy", {31'd0, rdy_m}, 32'd1);
    check("hold_ignored", {24'd0, data_m}, 32'h3C);

    // Reset mid-word after 4 bits, then a clean FF.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_bit   = i[0];
      tick();
    end
    check("mid_vld", {31'd0, vld_m}, 32'd0);
    rst      = 1'b1;
    in_bit   = 1'b1;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    check("mid_rst_data", {24'd0, data_m}, 32'h00);
    check("mid_rst_rdy", {31'd0, rdy_m}, 32'd1);
    send_word(8'hFF, 1'b0, 1'b0);
    check("ff_vld", {31'd0, vld_m}, 32'd1);
    check("ff_data", {24'd0, data_m}, 32'hFF);
    check("ff_data_l", {24'd0, data_l}, 32'hFF);
    tick();

    // Reset wins over a simultaneous word transfer in HOLD.
    out_ready = 1'b0;
    send_word(8'h81, 1'b1, 1'b0);
    check("hold81_data", {24'd0, data_m}, 32'h81);
    check("hold81_data_l", {24'd0, data_l}, 32'h81);
`ifdef BIT_DESER_PARITY_EN
    check("hold81_perr", {31'd0, perr_m}, 32'd1);
`endif
    out_ready = 1'b1;
    rst       = 1'b1;
    tick();
    rst = 1'b0;
    check("hrst_vld", {31'd0, vld_m}, 32'd0);
    check("hrst_rdy", {31'd0, rdy_m}, 32'd1);
    check("hrst_data", {24'd0, data_m}, 32'h00);
`ifdef BIT_DESER_PARITY_EN
    check("hrst_perr", {31'd0, perr_m}, 32'd0);
`endif

    // in_valid alternating 1,0 across the word.
    send_word(8'hB2, 1'b1, 1'b1);
    check("gap_vld", {31'd0, vld_m}, 32'd1);
    check("gap_data", {24'd0, data_m}, 32'hB2);
    check("gap_data_l", {24'd0, data_l}, 32'h4D);
    tick();
    check("gap_done", {31'd0, vld_m}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bit_deser.md
BIT_DESER -- requirements
Module: bit_deser

Interface
REQ-001 Parameter: WIDTH, 8, number of data bits per assembled word (>=2).
REQ-002 Parameter: MSB_FIRST, 1, 1 = first received bit lands in out_data[WIDTH-1]; 0 = first received bit lands in out_data[0].
REQ-003 Port: clk  input  1  sole clock, rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: in_valid  input  1  serial bit offered.
REQ-006 Port: in_bit  input  1  serial data bit.
REQ-007 Port: in_ready  output  1  block accepts a bit this cycle.
REQ-008 Port: out_valid  output  1  assembled word available.
REQ-009 Port: out_data  output  WIDTH  assembled word.
REQ-010 Port: out_ready  input  1  consumer accepts word this cycle.
REQ-011 Port (BIT_DESER_PARITY_EN only): parity_err  output  1  parity check result for the word on out_data.

Function
REQ-012 A bit transfers on a clk edge where in_valid && in_ready; a word transfers where out_valid && out_ready.
REQ-013 FSM states: SHIFT (collecting bits), PAR (parity bit, macro build only), HOLD (word presented).
REQ-014 SHIFT: in_ready=1, out_valid=0; a bit counter of $clog2(WIDTH) bits increments per accepted bit.
REQ-015 MSB_FIRST=1: shift register shifts left, new bit into bit 0; MSB_FIRST=0: shifts right, new bit into bit WIDTH-1.
REQ-016 On acceptance of bit number WIDTH-1 (counting from 0): counter clears; next state is HOLD (or PAR in macro build).
REQ-017 Latency: out_valid asserts on the cycle immediately after the final bit is accepted.
REQ-018 HOLD: in_ready=0, out_valid=1, out_data and parity_err held stable until the word transfers.
REQ-019 Word transfer in HOLD returns to SHIFT; in_ready is 1 on the following cycle (no same-cycle bit acceptance in HOLD).
REQ-020 in_valid gaps in SHIFT leave counter and shift register unchanged; no timeout.
REQ-021 in_bit is ignored whenever in_ready=0.
REQ-022 out_data equals the raw shift register; the MSB_FIRST=0 word is the bit-reversal of the MSB_FIRST=1 word for an identical bit stream.

Reset
REQ-023 rst forces state SHIFT, counter 0, shift register 0, out_valid 0, in_ready 1 (from the next cycle), parity_err 0.
REQ-024 rst mid-word or in HOLD discards partial/pending data; the next WIDTH accepted bits form a clean word.
REQ-025 rst has priority over any simultaneous handshake.

Configuration
REQ-026 Macro BIT_DESER_PARITY_EN: when defined, one extra serial bit follows each WIDTH data bits, accepted in state PAR (in_ready=1).
REQ-027 With macro: parity_err = XOR of the WIDTH data bits and the parity bit (even parity; 1 = error), registered on parity-bit acceptance, valid with out_valid.
REQ-028 Without macro: no PAR state, no parity_err port; SHIFT goes directly to HOLD.

Structure
REQ-029 Package bit_deser_pkg holds the state enum type and a parity-reduction function.
REQ-030 One sub-module, bit_deser_ctrl, holds FSM and bit counter; the top holds the shift register and output registers.

Verification
REQ-031 WIDTH=8, MSB_FIRST=1, bits 1,0,1,1,0,0,1,0 back-to-back, out_ready=1 -> out_data=8'hB2, out_valid high exactly 1 cycle, the cycle after the 8th bit.
REQ-032 WIDTH=8, MSB_FIRST=0, same stream -> out_data=8'h4D.
REQ-033 out_ready held 0 for 3 cycles in HOLD -> out_valid=1, in_ready=0, out_data stable for all 3 cycles; word transfers on the first cycle out_ready=1.
REQ-034 rst pulsed after 4 accepted bits, then stream 8'hFF -> out_data=8'hFF, no residue.
REQ-035 in_valid toggled 1,0,1,0 across the word with stream for 8'hB2 -> out_data=8'hB2.
REQ-036 Macro build, word 8'hB2 followed by parity bit 1 -> parity_err=1; followed by parity bit 0 -> parity_err=0.
